// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared command encoding, default timing and command decode for dram_model
package dram_pkg;

  localparam int DRAM_ROW_BITS = 11;
  localparam int DRAM_COL_BITS = 10;
  localparam int DRAM_CL       = 3;
  localparam int DRAM_RCD      = 2;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    PRE,
    RD,
    WR
  } dram_cmd_e;

  // RAS and CAS low together is not a legal command and falls through as NOP.
  function automatic dram_cmd_e dram_decode(
    input logic       cs_n,
    input logic       ras_n,
    input logic       cas_n,
    input logic [3:0] we_n
  );
    dram_cmd_e cmd;
    cmd = NOP;
    if (!cs_n) begin
      if (!ras_n && cas_n) begin
        cmd = (we_n == 4'hF) ? ACT : PRE;
      end else if (ras_n && !cas_n) begin
        cmd = (we_n == 4'hF) ? RD : WR;
      end
    end
    return cmd;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// rtl/dram_rd_pipe.sv - DEPTH-stage valid+data shift pipe; Q takes the word DEPTH cycles after issue
module dram_rd_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 32
) (
  input  logic         ck_i,
  input  logic         rst_ni,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     dat_q [DEPTH];
  logic [W-1:0]     dat_d [DEPTH];
  logic [W-1:0]     q_q, q_d;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = vld_i;
    dat_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    // Q holds the last completed read until another one falls out of the pipe.
    q_d = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : q_q;
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      q_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      q_q   <= q_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dram_model.sv
// rtl/dram_model.sv - cycle-accurate model of a 32-bit byte-writable DRAM with row/column addressing
module dram_model
  import dram_pkg::*;
#(
  parameter int ROW_BITS = DRAM_ROW_BITS,
  parameter int COL_BITS = DRAM_COL_BITS,
  parameter int CL       = DRAM_CL,
  parameter int RCD      = DRAM_RCD,
  parameter int WORDS    = 2 ** (ROW_BITS + COL_BITS)
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic [3:0]  WEn,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q
);

  localparam int IDX_W = ROW_BITS + COL_BITS;

  logic [7:0] Memory_byte0 [WORDS];
  logic [7:0] Memory_byte1 [WORDS];
  logic [7:0] Memory_byte2 [WORDS];
  logic [7:0] Memory_byte3 [WORDS];

  dram_cmd_e           cmd;
  logic                row_open_q, row_open_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [7:0]          rcd_q, rcd_d;
  logic                col_ok;
  logic                rd_fire, wr_fire;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         rd_word;

  assign cmd     = dram_decode(CSn, RASn, CASn, WEn);
  assign col_ok  = row_open_q && (rcd_q == 8'd0);
  assign rd_fire = (cmd == RD) && col_ok;
  assign wr_fire = (cmd == WR) && col_ok;
  assign idx     = {row_q, A[COL_BITS-1:0]};
  assign rd_word = {Memory_byte3[idx], Memory_byte2[idx], Memory_byte1[idx], Memory_byte0[idx]};

  // Counter loads RCD-1 so a column command RCD edges after ACTIVATE sees zero.
  always_comb begin
    row_open_d = row_open_q;
    row_d      = row_q;
    rcd_d      = (rcd_q != 8'd0) ? rcd_q - 8'd1 : rcd_q;
    case (cmd)
      ACT: begin
        if (!row_open_q) begin
          row_open_d = 1'b1;
          row_d      = A[ROW_BITS-1:0];
          rcd_d      = (RCD > 0) ? 8'(RCD - 1) : 8'd0;
        end
      end
      PRE:     row_open_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      row_open_q <= 1'b0;
      row_q      <= '0;
      rcd_q      <= '0;
    end else begin
      row_open_q <= row_open_d;
      row_q      <= row_d;
      rcd_q      <= rcd_d;
    end
  end

  always_ff @(posedge CK) begin
    if (wr_fire) begin
      if (!WEn[0]) Memory_byte0[idx] <= D[7:0];
      if (!WEn[1]) Memory_byte1[idx] <= D[15:8];
      if (!WEn[2]) Memory_byte2[idx] <= D[23:16];
      if (!WEn[3]) Memory_byte3[idx] <= D[31:24];
    end
  end

  dram_rd_pipe #(
    .DEPTH (CL),
    .W     (32)
  ) u_rd_pipe (
    .ck_i   (CK),
    .rst_ni (RST),
    .vld_i  (rd_fire),
    .data_i (rd_word),
    .q_o    (Q)
  );

endmodule

// File: tb/tb_dram_model.sv
// tb/tb_dram_model.sv - directed self-checking bench for dram_model
module tb_dram_model;

  logic        CK;
  logic        RST;
  logic        CSn;
  logic        RASn;
  logic        CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;

  int checks;
  int errors;

  dram_model dut (
    .CK   (CK),
    .RST  (RST),
    .CSn  (CSn),
    .RASn (RASn),
    .CASn (CASn),
    .WEn  (WEn),
    .A    (A),
    .D    (D),
    .Q    (Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic issue(input logic ras_n, input logic cas_n, input logic [3:0] we_n,
                       input logic [10:0] a, input logic [31:0] d);
    CSn  = 1'b0;
    RASn = ras_n;
    CASn = cas_n;
    WEn  = we_n;
    A    = a;
    D    = d;
    @(posedge CK);
    #1;
    CSn  = 1'b1;
    RASn = 1'b1;
    CASn = 1'b1;
    WEn  = 4'hF;
  endtask

  task automatic do_act(input logic [10:0] row);
    issue(1'b0, 1'b1, 4'hF, row, 32'h0);
  endtask

  task automatic do_pre();
    issue(1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
  endtask

  task automatic do_rd(input logic [10:0] col);
    issue(1'b1, 1'b0, 4'hF, col, 32'h0);
  endtask

  task automatic do_wr(input logic [10:0] col, input logic [31:0] d, input logic [3:0] we_n);
    issue(1'b1, 1'b0, we_n, col, d);
  endtask

  task automatic preload(input logic [20:0] idx, input logic [31:0] w);
    dut.Memory_byte0[idx] = w[7:0];
    dut.Memory_byte1[idx] = w[15:8];
    dut.Memory_byte2[idx] = w[23:16];
    dut.Memory_byte3[idx] = w[31:24];
  endtask

  task automatic test_reset();
    logic [31:0] mem;
    preload(21'h40000, 32'h12345678);
    RST  = 1'b0;
    CSn  = 1'b0;
    RASn = 1'b1;
    CASn = 1'b0;
    WEn  = 4'h0;
    A    = 11'h000;
    D    = 32'hCAFEF00D;
    idle(1);
    A    = 11'h7FF;
    D    = 32'h5A5AA5A5;
    idle(1);
    checks++;
    if (Q !== 32'h0) begin
      errors++;
      $display("FAIL reset_q: got %h expected %h", Q, 32'h0);
    end
    mem = {dut.Memory_byte3[21'h40000], dut.Memory_byte2[21'h40000],
           dut.Memory_byte1[21'h40000], dut.Memory_byte0[21'h40000]};
    checks++;
    if (mem !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_mem: got %h expected %h", mem, 32'h12345678);
    end
    CSn  = 1'b1;
    RASn = 1'b1;
    CASn = 1'b1;
    WEn  = 4'hF;
    RST  = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    logic [31:0] mem;
    do_act(11'h100);
    idle(1);
    do_wr(11'h000, 32'hDEADBEEF, 4'h0);
    do_rd(11'h000);
    idle(2);
    checks++;
    if (Q !== 32'h0) begin
      errors++;
      $display("FAIL basic_not_early: got %h expected %h", Q, 32'h0);
    end
    idle(1);
    checks++;
    if (Q !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_read_cl: got %h expected %h", Q, 32'hDEADBEEF);
    end
    mem = {dut.Memory_byte3[21'h40000], dut.Memory_byte2[21'h40000],
           dut.Memory_byte1[21'h40000], dut.Memory_byte0[21'h40000]};
    checks++;
    if (mem !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_mem_bytes: got %h expected %h", mem, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_mask();
    preload(21'h40001, 32'hAABBCCDD);
    do_wr(11'h001, 32'h11223344, 4'b1010);
    do_rd(11'h001);
    idle(3);
    checks++;
    if (Q !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_mask: got %h expected %h", Q, 32'hAA22CC44);
    end
  endtask

  task automatic test_violations();
    preload(21'h80005, 32'h55550005);
    preload(21'h40005, 32'h11110005);
    do_pre();
    do_rd(11'h000);
    idle(4);
    checks++;
    if (Q !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL read_closed_row: got %h expected %h", Q, 32'hAA22CC44);
    end
    do_act(11'h200);
    do_rd(11'h005);
    idle(4);
    checks++;
    if (Q !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL read_rcd_early: got %h expected %h", Q, 32'hAA22CC44);
    end
    do_act(11'h100);
    do_rd(11'h005);
    idle(3);
    checks++;
    if (Q !== 32'h55550005) begin
      errors++;
      $display("FAIL act_while_open: got %h expected %h", Q, 32'h55550005);
    end
  endtask

  task automatic test_pipelined();
    logic [31:0] exp_q [4];
    for (int i = 0; i < 4; i++) begin
      preload(21'h80000 + 21'(i), 32'(i));
    end
    exp_q[0] = 32'd1;
    exp_q[1] = 32'd2;
    exp_q[2] = 32'd3;
    exp_q[3] = 32'd3;
    do_rd(11'h000);
    do_rd(11'h001);
    do_rd(11'h002);
    checks++;
    if (Q !== 32'h55550005) begin
      errors++;
      $display("FAIL pipe_not_early: got %h expected %h", Q, 32'h55550005);
    end
    do_rd(11'h003);
    checks++;
    if (Q !== 32'd0) begin
      errors++;
      $display("FAIL pipe_q0: got %h expected %h", Q, 32'd0);
    end
    do_pre();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Q !== exp_q[i]) begin
        errors++;
        $display("FAIL pipe_q%0d: got %h expected %h", i + 1, Q, exp_q[i]);
      end
      idle(1);
    end
  endtask

  task automatic test_col_wrap();
    do_act(11'h200);
    idle(1);
    do_rd(11'h401);
    idle(3);
    checks++;
    if (Q !== 32'd1) begin
      errors++;
      $display("FAIL col_wrap: got %h expected %h", Q, 32'd1);
    end
  endtask

  task automatic test_reset_mid_read();
    do_rd(11'h002);
    idle(1);
    RST = 1'b0;
    #1;
    checks++;
    if (Q !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_q: got %h expected %h", Q, 32'h0);
    end
    idle(1);
    RST = 1'b1;
    idle(3);
    checks++;
    if (Q !== 32'h0) begin
      errors++;
      $display("FAIL rst_discard: got %h expected %h", Q, 32'h0);
    end
    do_act(11'h100);
    idle(1);
    do_rd(11'h000);
    idle(3);
    checks++;
    if (Q !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_recover: got %h expected %h", Q, 32'hDEADBEEF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST  = 1'b0;
    CSn  = 1'b1;
    RASn = 1'b1;
    CASn = 1'b1;
    WEn  = 4'hF;
    A    = 11'h0;
    D    = 32'h0;
    test_reset();
    test_basic();
    test_byte_mask();
    test_violations();
    test_pipelined();
    test_col_wrap();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
